load_function: RTL and testbench
================================

Name: load_function

Overview:
- Load-side counterpart of the byte-enabled store path into datamemory.
- Accepts one load request at a time: byte address plus RISC-V funct3.
- Issues synchronous word reads to the data memory, then extracts the addressed byte, halfword or word.
- Sign- or zero-extends the result and returns it with a valid/ready response handshake.

Parameters:
- DM_ADDRESS, 9: byte-address width of data memory; word index width is DM_ADDRESS-2.
- DATA_W, 32: data width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  load request valid
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_addr  in  32  byte address; only bits [DM_ADDRESS-1:0] are used
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_re  out  1  data memory read enable
- mem_addr  out  DM_ADDRESS-2  word index to memory
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re
- rsp_valid  out  1  response valid; held until accepted
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  extended load result
- rsp_err  out  1  request rejected (illegal funct3, or misaligned without feature)

Behaviour:
- Reset (async, rst_n low): state=IDLE, mem_re=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, captured words=0. req_ready reads 1 (IDLE decode); requests are ignored while rst_n is low. Reset mid-operation aborts the load and drops any pending response.
- States: IDLE, ISSUE0, DATA0, DATA1, RESP.
- IDLE: on req_valid&&req_ready, latch addr and funct3.
  - Illegal funct3 (011/110/111) goes straight to RESP with rsp_err=1, rsp_data=0, and no memory access.
  - Otherwise go to ISSUE0.
- ISSUE0: mem_re=1, mem_addr=addr[DM_ADDRESS-1:2]; next state DATA0.
- DATA0: capture mem_rdata as lo.
  - Split access (LW with addr[1:0]!=0, or LH with addr[1:0]==3): mem_re=1, mem_addr=word index+1, which wraps modulo 2^(DM_ADDRESS-2); next state DATA1.
  - Otherwise go to RESP.
- DATA1: capture mem_rdata as hi; next state RESP.
- Extraction: the 64-bit value {hi,lo} (hi=0 if not split) is shifted right by 8*addr[1:0], and the low 32 bits are used.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW uses all 32 bits.
- RESP: rsp_valid=1, with rsp_data/rsp_err registered and stable. When rsp_ready is high, go to IDLE next cycle, clearing rsp_valid. No new request is accepted in the same cycle.
- Latency from the accept edge to rsp_valid high:
  - aligned: 3 cycles
  - split: 4 cycles
  - error: 1 cycle
- mem_re is never high outside ISSUE0/DATA0; at most 2 reads per request.

Optional Feature:
- Macro: MISALIGNED_LOAD_EN.
- Defined: split accesses are performed as above (two reads, spanning a word boundary, including wrap).
- Undefined: any LW with addr[1:0]!=0, or LH/LHU with addr[0]=1, is rejected. Behaviour is the same as illegal funct3: rsp_err=1, rsp_data=0, no mem_re, 1-cycle latency. DATA1 is unreachable.

Test Plan:
- Memory word0=0x884422F1, word1=0x12345678; LB addr 0x000 -> rsp_data=0xFFFFFFF1, err=0, rsp_valid 3 cycles after accept, exactly one mem_re pulse with mem_addr=0.
- LBU addr 0x003 -> 0x00000088; LH addr 0x002 -> 0xFFFF8844; LHU addr 0x002 -> 0x00008844; LW addr 0x004 -> 0x12345678.
- With MISALIGNED_LOAD_EN:
  - LW addr 0x001 -> 0x78884422, mem_addr 0 then 1 on consecutive cycles, 4-cycle latency.
  - DM_ADDRESS=9, word127=0xAABBCCDD, LW addr 0x1FE -> second read at mem_addr 0, result 0x22F1AABB.
- Without MISALIGNED_LOAD_EN: LW addr 0x001 -> rsp_err=1, rsp_data=0, mem_re never asserted; funct3=011 at addr 0 -> same error response.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable and req_ready=0 throughout; raise rsp_ready -> rsp_valid=0 and req_ready=1 next cycle.
- Drive rst_n low in DATA0 of a split load -> mem_re=0 and rsp_valid=0 immediately. After release, a fresh LB addr 0 returns 0xFFFFFFF1 with no stale data.

Source files
------------

// File: rtl/load_function_if.sv
// load_function_if: request, memory-read and response signals of the load unit.
interface load_function_if #(parameter int DM_ADDRESS = 9, parameter int DATA_W = 32);
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic [2:0]            req_funct3;
    logic                  mem_re;
    logic [DM_ADDRESS-3:0] mem_addr;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_err;
    modport master (
        output req_valid, req_addr, req_funct3, mem_rdata, rsp_ready,
        input  req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, req_funct3, mem_rdata, rsp_ready,
        output req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_function.sv
// load_function: byte/half/word loads from word-wide data memory with sign/zero extension.
// MISALIGNED_LOAD_EN enables word-crossing loads via two reads; otherwise they are rejected.
module load_function #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input logic          clk,
    input logic          rst_n,
    load_function_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE0, DATA0, DATA1, RESP} state_t;

    state_t                state_q, state_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [2:0]            f3_q, f3_d;
    logic [DATA_W-1:0]     lo_q, lo_d, data_q, data_d;
    logic                  err_q, err_d;
    logic [DM_ADDRESS-3:0] widx;
    logic                  bad_f3, reject, split;
    logic                  unused_addr;

    function automatic logic [31:0] extract(input logic [63:0] v, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [31:0] w;
        w = 32'(v >> {off, 3'b000});
        return f3 == 3'b000 ? {{24{w[7]}}, w[7:0]} :
               f3 == 3'b001 ? {{16{w[15]}}, w[15:0]} :
               f3 == 3'b100 ? {24'd0, w[7:0]} :
               f3 == 3'b101 ? {16'd0, w[15:0]} : w;
    endfunction

    assign unused_addr = ^bus.req_addr[31:DM_ADDRESS];
    assign bad_f3      = bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11;
    assign widx        = addr_q[DM_ADDRESS-1:2];

`ifdef MISALIGNED_LOAD_EN
    assign reject = bad_f3;
    assign split  = (f3_q == 3'b010 && addr_q[1:0] != 2'b00) ||
                    (f3_q[1:0] == 2'b01 && addr_q[1:0] == 2'b11);
`else
    assign reject = bad_f3 || (bus.req_funct3 == 3'b010 && bus.req_addr[1:0] != 2'b00) ||
                    (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]);
    assign split  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d  = bus.req_addr[DM_ADDRESS-1:0];
                f3_d    = bus.req_funct3;
                data_d  = '0;
                err_d   = reject;
                state_d = reject ? RESP : ISSUE0;
            end
            ISSUE0: state_d = DATA0;
            DATA0: begin
                lo_d    = bus.mem_rdata;
                data_d  = extract({32'd0, bus.mem_rdata}, addr_q[1:0], f3_q);
                state_d = split ? DATA1 : RESP;
            end
            DATA1: begin
                data_d  = extract({bus.mem_rdata, lo_q}, addr_q[1:0], f3_q);
                state_d = RESP;
            end
            RESP: state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Second read of a split access targets the next word, wrapping at the top of memory.
    assign bus.req_ready = state_q == IDLE;
    assign bus.mem_re    = state_q == ISSUE0 || (state_q == DATA0 && split);
    assign bus.mem_addr  = state_q == DATA0 ? widx + 1'b1 : widx;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_load_function.sv
// tb_load_function: randomized and directed checks of load_function against a byte-level model.
module tb_load_function;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] mem [128];
    int rd_q[$];
    int n_vec = 0;
    int n_err = 0;

    load_function_if #(.DM_ADDRESS(9), .DATA_W(32)) bus();
    load_function #(.DM_ADDRESS(9), .DATA_W(32)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            rd_q.push_back(int'(bus.mem_addr));
        end
    end

    function automatic logic [7:0] byte_at(input int x);
        logic [31:0] w;
        w = mem[x / 4];
        return w[8 * (x % 4) +: 8];
    endfunction

    function automatic void model(input logic [8:0] a, input logic [2:0] f3, output logic err,
                                  output logic [31:0] d, output int lat, output int n,
                                  output int w0, output int w1);
        int size;
        logic ill, mis, spl;
        size = 1 << f3[1:0];
        ill  = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
        mis  = size > 1 && (int'(a) % size) != 0;
        spl  = (int'(a) % 4) + size > 4;
`ifdef MISALIGNED_LOAD_EN
        err = ill;
`else
        err = ill || mis;
`endif
        d  = 0;
        w0 = int'(a) / 4;
        w1 = (w0 + 1) % 128;
        if (err) begin
            lat = 1;
            n   = 0;
            return;
        end
        for (int i = 0; i < size; i++) d |= 32'(byte_at((int'(a) + i) % 512)) << (8 * i);
        if (!f3[2] && size < 4 && d[8 * size - 1]) d |= ~((32'h1 << (8 * size)) - 1);
        n   = spl ? 2 : 1;
        lat = spl ? 4 : 3;
    endfunction

    task automatic test_load(input logic [8:0] a, input logic [2:0] f3, input int hold,
                             output logic [31:0] got);
        logic e_err;
        logic [31:0] e_d;
        int e_lat, e_n, e_w0, e_w1, lat, wt;
        model(a, f3, e_err, e_d, e_lat, e_n, e_w0, e_w1);
        @(negedge clk);
        wt = 0;
        while (!bus.req_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        n_vec++;
        if (!bus.req_ready) begin
            n_err++;
            $display("FAIL req_ready_wait: req_ready=%0b required 1", bus.req_ready);
        end
        rd_q.delete();
        bus.req_valid  = 1'b1;
        bus.req_addr   = {23'($urandom), a};
        bus.req_funct3 = f3;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        got = bus.rsp_data;
        n_vec++;
        if (lat !== e_lat) begin
            n_err++;
            $display("FAIL latency a=%h f3=%b: got %0d required %0d", a, f3, lat, e_lat);
        end
        n_vec++;
        if (bus.rsp_err !== e_err || bus.rsp_data !== e_d) begin
            n_err++;
            $display("FAIL rsp a=%h f3=%b: got err=%b data=%h required err=%b data=%h",
                     a, f3, bus.rsp_err, bus.rsp_data, e_err, e_d);
        end
        n_vec++;
        if (rd_q.size() !== e_n || (e_n > 0 && rd_q[0] !== e_w0) || (e_n > 1 && rd_q[1] !== e_w1)) begin
            n_err++;
            $display("FAIL reads a=%h f3=%b: got %0d reads first=%0d required %0d reads at %0d,%0d",
                     a, f3, rd_q.size(), rd_q.size() > 0 ? rd_q[0] : -1, e_n, e_w0, e_w1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== got || bus.req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold cyc%0d: valid=%b data=%h req_ready=%b required 1,%h,0",
                         i, bus.rsp_valid, bus.rsp_data, bus.req_ready, got);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release: valid=%b req_ready=%b required 0,1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0;
        bus.req_funct3 = 3'b010;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 7'd0 ||
            bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'd0 || bus.rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset: rdy=%b re=%b maddr=%h vld=%b data=%h err=%b required 1,0,0,0,0,0",
                     bus.req_ready, bus.mem_re, bus.mem_addr, bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: rdy=%b vld=%b required 1,0", bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] got;
        test_load(9'h000, 3'b000, 0, got);
        n_vec++;
        if (got !== 32'hFFFFFFF1) begin n_err++; $display("FAIL lb0: got %h required FFFFFFF1", got); end
        test_load(9'h003, 3'b100, 0, got);
        n_vec++;
        if (got !== 32'h00000088) begin n_err++; $display("FAIL lbu3: got %h required 00000088", got); end
        test_load(9'h002, 3'b001, 0, got);
        n_vec++;
        if (got !== 32'hFFFF8844) begin n_err++; $display("FAIL lh2: got %h required FFFF8844", got); end
        test_load(9'h002, 3'b101, 0, got);
        n_vec++;
        if (got !== 32'h00008844) begin n_err++; $display("FAIL lhu2: got %h required 00008844", got); end
        test_load(9'h004, 3'b010, 0, got);
        n_vec++;
        if (got !== 32'h12345678) begin n_err++; $display("FAIL lw4: got %h required 12345678", got); end
        test_load(9'h000, 3'b011, 0, got);
        n_vec++;
        if (got !== 32'h0 || bus.rsp_err !== 1'b1) begin
            n_err++;
            $display("FAIL f3_011: data %h err %b required 00000000 1", got, bus.rsp_err);
        end
`ifdef MISALIGNED_LOAD_EN
        test_load(9'h001, 3'b010, 0, got);
        n_vec++;
        if (got !== 32'h78884422) begin n_err++; $display("FAIL lw1: got %h required 78884422", got); end
        test_load(9'h1FE, 3'b010, 0, got);
        n_vec++;
        if (got !== 32'h22F1AABB) begin n_err++; $display("FAIL lw1fe: got %h required 22F1AABB", got); end
`else
        test_load(9'h001, 3'b010, 0, got);
        n_vec++;
        if (got !== 32'h0) begin n_err++; $display("FAIL lw1_reject: got %h required 00000000", got); end
        test_load(9'h003, 3'b101, 0, got);
        n_vec++;
        if (got !== 32'h0) begin n_err++; $display("FAIL lhu3_reject: got %h required 00000000", got); end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        test_load(9'h004, 3'b010, 5, got);
        n_vec++;
        if (got !== 32'h12345678) begin n_err++; $display("FAIL bp_data: got %h required 12345678", got); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        @(negedge clk);
        bus.req_valid  = 1'b1;
`ifdef MISALIGNED_LOAD_EN
        bus.req_addr   = 32'h1;
`else
        bus.req_addr   = 32'h4;
`endif
        bus.req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.mem_re !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: re=%b vld=%b rdy=%b required 0,0,1",
                     bus.mem_re, bus.rsp_valid, bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_load(9'h000, 3'b000, 0, got);
        n_vec++;
        if (got !== 32'hFFFFFFF1) begin n_err++; $display("FAIL after_reset_lb: got %h required FFFFFFF1", got); end
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        for (int i = 0; i < 60; i++)
            test_load(9'($urandom_range(511)), 3'($urandom_range(7)), $urandom_range(3), got);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]   = 32'h884422F1;
        mem[1]   = 32'h12345678;
        mem[127] = 32'hAABBCCDD;
        bus.mem_rdata = 32'h0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
